// File: rtl/relu_pkg.sv
// Shared types and helpers for the ReLU vector sequencer.
package relu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } relu_seq_state_e;

  // Number of datapath beats needed to sweep an n-element vector with p lanes.
  function automatic int relu_beats(int n, int p);
    return n / p;
  endfunction

endpackage

// File: rtl/relu_lane.sv
// P-lane combinational rectifier: max(0,x) per lane plus a mask of the lanes
// that were negative (and therefore clamped).
module relu_lane
  import relu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int P     = 2
) (
  input  logic signed [WIDTH-1:0] din    [P],
  output logic signed [WIDTH-1:0] dout   [P],
  output logic        [P-1:0]     is_neg
);

  // Sign bit alone decides the clamp; zero passes through and is not flagged.
  always_comb begin
    for (int i = 0; i < P; i++) begin
      is_neg[i] = din[i][WIDTH-1];
      dout[i]   = din[i][WIDTH-1] ? '0 : din[i];
    end
  end

endmodule

// File: rtl/relu_seq_ctrl.sv
// Vector ReLU sequencer: captures an N-element vector, rectifies it P lanes
// per cycle over N/P beats, then offers the result with a clamped-element
// count on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for a vector; in_ready=1
// RUN   | sweeping buffer through relu_lane one beat per cycle
// DONE  | result held on out_vec/neg_count until out_ready; in_ready=out_ready
module relu_seq_ctrl
  import relu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int P     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  in_vec    [0:N-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WIDTH-1:0]  out_vec   [0:N-1],
  output logic [$clog2(N+1)-1:0]   neg_count,
  output logic                     busy
);

  localparam int BEATS = relu_beats(N, P);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(N + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if ((N % P) != 0) begin : g_cfg_check
    $error("relu_seq_ctrl: N (%0d) must be a multiple of P (%0d)", N, P);
  end

  relu_seq_state_e state, state_nxt;
  logic [BW-1:0]            beat;
  logic signed [WIDTH-1:0]  vbuf     [0:N-1];
  logic signed [WIDTH-1:0]  lane_din [P];
  logic signed [WIDTH-1:0]  lane_dout[P];
  logic [P-1:0]             lane_neg;
  logic [CW-1:0]            lane_neg_cnt;
  logic                     capture;

  relu_lane #(.WIDTH(WIDTH), .P(P)) u_lane (
    .din    (lane_din),
    .dout   (lane_dout),
    .is_neg (lane_neg)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; DONE with out_ready retires and may start the next vector on the same edge.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid)            state_nxt = RUN;
      RUN:  if (beat == LAST_BEAT)   state_nxt = DONE;
      DONE: if (out_ready)           state_nxt = in_valid ? RUN : IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state; in_ready follows out_ready only in DONE.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE:    in_ready = 1'b1;
      RUN:     in_ready = 1'b0;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
    capture = in_valid & in_ready;
  end

  // Select the current beat's slice of the buffer and popcount its clamp mask.
  always_comb begin
    lane_neg_cnt = '0;
    for (int i = 0; i < P; i++) begin
      lane_din[i]  = vbuf[int'(beat) * P + i];
      lane_neg_cnt = lane_neg_cnt + CW'(lane_neg[i]);
    end
  end

  // Datapath: capture on handshake, write one slice of out_vec per RUN beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat      <= '0;
      neg_count <= '0;
      for (int i = 0; i < N; i++) begin
        vbuf[i]    <= '0;
        out_vec[i] <= '0;
      end
    end else if (capture) begin
      beat      <= '0;
      neg_count <= '0;
      for (int i = 0; i < N; i++) vbuf[i] <= in_vec[i];
    end else if (state == RUN) begin
      for (int i = 0; i < P; i++) out_vec[int'(beat) * P + i] <= lane_dout[i];
      neg_count <= neg_count + lane_neg_cnt;
      beat      <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
    end
  end

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Directed bench for relu_seq_ctrl (N=4,P=2 main instance, N=P=4 single-beat
// instance) with a short randomized stream checked against a max(0,x) model.
module tb_relu_seq_ctrl;

  logic clk;
  logic rst_n;

  logic               in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [15:0] in_vec  [0:3];
  logic signed [15:0] out_vec [0:3];
  logic [2:0]         neg_count;

  logic               in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic signed [15:0] in_vec1  [0:3];
  logic signed [15:0] out_vec1 [0:3];
  logic [2:0]         neg_count1;

  int n_tests = 0;
  int n_fail  = 0;

  relu_seq_ctrl #(.WIDTH(16), .N(4), .P(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .neg_count (neg_count),
    .busy      (busy)
  );

  relu_seq_ctrl #(.WIDTH(16), .N(4), .P(4)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_vec    (in_vec1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_vec   (out_vec1),
    .neg_count (neg_count1),
    .busy      (busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [63:0] v);
    in_vec[0] = v[63:48];
    in_vec[1] = v[47:32];
    in_vec[2] = v[31:16];
    in_vec[3] = v[15:0];
  endtask

  function automatic logic [63:0] pack4(input logic signed [15:0] v [0:3]);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // Independent reference: rectify each 16-bit element, count negatives.
  task automatic relu_model(input logic [63:0] v, output logic [63:0] e, output int n);
    logic [15:0] x;
    e = '0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      x = v[63 - 16*k -: 16];
      if (x[15]) n++;
      else       e[63 - 16*k -: 16] = x;
    end
  endtask

  logic [63:0] exp_q[$];
  int          expn_q[$];

  initial begin
    logic [63:0] cur, e;
    logic [31:0] rnd;
    int          n, sent, got, cyc;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; set_vec('0);
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    for (int k = 0; k < 4; k++) in_vec1[k] = '0;

    // Reset state, checked while reset is still asserted.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_neg_count", neg_count, 0);
    check("rst_out_vec", pack4(out_vec), 0);
    @(negedge clk) rst_n = 1'b1;

    // 1: basic vector incl. zero and most-negative value.
    tick();
    set_vec(64'h0005_fffd_0000_8000); in_valid = 1'b1; out_ready = 1'b1;
    #1 check("t1_in_ready_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1 check("t1_busy_run", busy, 1);
    check("t1_in_ready_run", in_ready, 0);
    check("t1_out_valid_early0", out_valid, 0);
    tick();
    check("t1_out_valid_early1", out_valid, 0);
    tick();
    check("t1_out_valid", out_valid, 1);
    check("t1_out_vec", pack4(out_vec), 64'h0005_0000_0000_0000);
    check("t1_neg_count", neg_count, 2);
    tick();
    check("t1_retired", out_valid, 0);
    check("t1_idle_busy", busy, 0);

    // 2: back-pressure for 10 cycles with a new vector waiting.
    set_vec(64'h0064_fff9_fff8_0009); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    set_vec(64'hffff_ffff_ffff_ffff);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      #1;
      check("t2_in_ready_stall", in_ready, 0);
      check("t2_out_valid_hold", out_valid, 1);
      check("t2_out_vec_hold", pack4(out_vec), 64'h0064_0000_0000_0009);
      tick();
    end
    check("t2_neg_count", neg_count, 2);

    // 3: zero-bubble handoff into an all-negative vector.
    out_ready = 1'b1;
    #1 check("t3_in_ready_follow", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1 check("t3_retired", out_valid, 0);
    check("t3_busy", busy, 1);
    tick();
    tick();
    check("t3_out_valid", out_valid, 1);
    check("t3_out_vec", pack4(out_vec), 64'h0);
    check("t3_neg_count", neg_count, 4);
    tick();
    check("t3_idle", out_valid, 0);

    // 5: all positive; input changes during RUN must not leak into the result.
    set_vec(64'h7fff_0001_0002_0003); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    set_vec(64'hfffb_fffb_fffb_fffb);
    tick();
    tick();
    check("t5_out_valid", out_valid, 1);
    check("t5_out_vec", pack4(out_vec), 64'h7fff_0001_0002_0003);
    check("t5_neg_count", neg_count, 0);
    tick();

    // 4: asynchronous reset during RUN beat 0 discards the vector.
    set_vec(64'h0001_fffe_0003_fffc); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t4_out_valid", out_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_in_ready", in_ready, 1);
    check("t4_neg_count", neg_count, 0);
    check("t4_out_vec", pack4(out_vec), 0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_no_emit", out_valid, 0);
    end

    // Single-beat configuration: result one edge after capture.
    in_vec1[0] = -16'sd1; in_vec1[1] = 16'sd2; in_vec1[2] = -16'sd3; in_vec1[3] = 16'sd4;
    in_valid1 = 1'b1; out_ready1 = 1'b1;
    #1 check("p4_in_ready", in_ready1, 1);
    tick();
    in_valid1 = 1'b0;
    #1 check("p4_busy", busy1, 1);
    check("p4_out_valid_early", out_valid1, 0);
    tick();
    check("p4_out_valid", out_valid1, 1);
    check("p4_out_vec", pack4(out_vec1), 64'h0000_0002_0000_0004);
    check("p4_neg_count", neg_count1, 2);
    tick();

    // 6: random stream with random back-pressure against the reference model.
    sent = 0; got = 0; cyc = 0;
    while (got < 200 && cyc < 5000) begin
      in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      for (int k = 0; k < 4; k++) begin
        rnd = $urandom;
        case ($urandom_range(0, 7))
          0:       cur[63 - 16*k -: 16] = 16'h8000;
          1:       cur[63 - 16*k -: 16] = 16'h0000;
          2:       cur[63 - 16*k -: 16] = 16'h7fff;
          3:       cur[63 - 16*k -: 16] = 16'hffff;
          default: cur[63 - 16*k -: 16] = rnd[15:0];
        endcase
      end
      set_vec(cur);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          n = expn_q.pop_front();
          check("rnd_out_vec", pack4(out_vec), e);
          check("rnd_neg_count", neg_count, n);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        relu_model(cur, e, n);
        exp_q.push_back(e);
        expn_q.push_back(n);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_results_retired", got, 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
